// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle passed from the timing generator down the draw chain.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counter with registered, zero-skew sync/blank and frame/line strobes.
// Latency: none between count and its sync/blank; no backpressure, the raster never stalls.
module vga_timing_gen #(
  parameter int         H_ACTIVE = 800,
  parameter int         H_FP     = 40,
  parameter int         H_SYNC   = 128,
  parameter int         H_BP     = 88,
  parameter int         V_ACTIVE = 600,
  parameter int         V_FP     = 1,
  parameter int         V_SYNC   = 4,
  parameter int         V_BP     = 23,
  parameter logic       SYNC_POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  vga_if.out   vga_out,
  output logic frame_start,
  output logic line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL >= 2048 || V_TOTAL >= 2048) begin : g_size_err
    $error("vga_timing_gen: raster totals must fit an 11-bit counter");
  end

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, vcount_q;
  logic [10:0] h_nxt, v_nxt;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic        h_last;

  // Decode from the next count so every flag lands on the same edge as its count.
  always_comb begin
    h_last = (hcount_q == H_LAST);
    h_nxt  = h_last ? 11'd0 : hcount_q + 11'd1;
    v_nxt  = vcount_q;
    if (h_last) begin
      v_nxt = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q    <= 11'd0;
      vcount_q    <= 11'd0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount_q    <= h_nxt;
      vcount_q    <= v_nxt;
      hblnk_q     <= (h_nxt >= H_ACT);
      vblnk_q     <= (v_nxt >= V_ACT);
      hsync_q     <= (h_nxt >= HS_START && h_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_q     <= (v_nxt >= VS_START && v_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
      line_start  <= (h_nxt == 11'd0);
      frame_start <= (h_nxt == 11'd0) && (v_nxt == 11'd0);
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;

endmodule
